// File: rtl/aes_job_scheduler.sv
// AES job scheduler: arbitrates two requesters onto one AES core with a fixed
// latency, keeps exactly one job in flight and holds the result until consumed.
module aes_job_scheduler #(
  parameter int LATENCY = 11,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic [127:0] aes_Data_in,
  output logic [127:0] aes_key_in,
  input  logic [127:0] aes_cipher_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_cipher,
  output logic         res_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t       state_q, state_d;
  logic         rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         res_valid_q, res_valid_d;
  logic [127:0] res_cipher_q, res_cipher_d;
  logic         res_id_q, res_id_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;

  logic grant0, grant1;
  logic accept0, accept1;

  // Grant: a lone requester wins; on contention the round-robin pointer decides.
  always_comb begin
    grant0  = req0_valid && (!req1_valid || !rr_q);
    grant1  = req1_valid && (!req0_valid ||  rr_q);
    req0_ready = !rst && (state_q == IDLE) && grant0;
    req1_ready = !rst && (state_q == IDLE) && grant1;
    accept0 = req0_valid && req0_ready;
    accept1 = req1_valid && req1_ready;
  end

  // Next-state logic: accept in IDLE, count down in RUN, hold the result in DONE.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    res_valid_d  = res_valid_q;
    res_cipher_d = res_cipher_q;
    res_id_d     = res_id_q;
    data_d       = data_q;
    key_d        = key_q;
    unique case (state_q)
      IDLE: begin
        if (accept0) begin
          data_d   = req0_data;
          key_d    = req0_key;
          res_id_d = 1'b0;
          cnt_d    = CNT_LOAD;
          state_d  = RUN;
        end else if (accept1) begin
          data_d   = req1_data;
          key_d    = req1_key;
          res_id_d = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          // The core output has had LATENCY cycles to settle on the held inputs.
          res_cipher_d = aes_cipher_out;
          res_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_d        = ~res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_cipher_q <= '0;
      res_id_q     <= 1'b0;
      data_q       <= '0;
      key_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_cipher_q <= res_cipher_d;
      res_id_q     <= res_id_d;
      data_q       <= data_d;
      key_q        <= key_d;
    end
  end

  assign aes_Data_in = data_q;
  assign aes_key_in  = key_q;
  assign res_valid   = res_valid_q;
  assign res_cipher  = res_cipher_q;
  assign res_id      = res_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a latency-aware AES core stand-in.
module tb_aes_job_scheduler;

  localparam int LATENCY = 11;

  localparam logic [127:0] V1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic [127:0] aes_Data_in, aes_key_in, aes_cipher_out;
  logic         res_valid, res_id, busy;
  logic         res_ready = 1'b1;
  logic [127:0] res_cipher;

  aes_job_scheduler #(.LATENCY(LATENCY), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .aes_Data_in(aes_Data_in), .aes_key_in(aes_key_in), .aes_cipher_out(aes_cipher_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_cipher(res_cipher), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: known vectors map to their ciphertexts, but the output is only
  // correct once the inputs have been held for the full latency; before that it is junk.
  int unsigned  stab = 0;
  logic [255:0] last_dk;
  always @(posedge clk) begin
    if ({aes_Data_in, aes_key_in} !== last_dk) begin
      last_dk <= {aes_Data_in, aes_key_in};
      stab    <= 0;
    end else if (stab < 100) begin
      stab <= stab + 1;
    end
  end

  function automatic logic [127:0] core_model(input logic [127:0] d, input logic [127:0] k);
    if (d == V1 && k == K1) return C1;
    if (d == V2 && k == K2) return C2;
    return d ^ k ^ JUNK;
  endfunction

  assign aes_cipher_out = (stab >= LATENCY - 2) ? core_model(aes_Data_in, aes_key_in) : JUNK;

  // Transaction monitor: logs acceptances and result handshakes with edge numbers.
  int n_acc = 0, n_res = 0, cyc = 0;
  int acc_cyc [0:31];
  logic acc_id [0:31];
  logic [127:0] r_cip [0:31];
  logic r_id [0:31];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      acc_cyc[n_acc] <= cyc + 1;
      acc_id[n_acc]  <= req1_valid && req1_ready;
      n_acc          <= n_acc + 1;
      $display("ACCEPT req%0d at edge %0d", (req1_valid && req1_ready) ? 1 : 0, cyc + 1);
    end
    if (res_valid && res_ready) begin
      r_cip[n_res] <= res_cipher;
      r_id[n_res]  <= res_id;
      n_res        <= n_res + 1;
      $display("RESULT id=%0d cipher=%h at edge %0d", res_id, res_cipher, cyc + 1);
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input int target, input string tag);
    int k = 0;
    while (n_acc < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (n_acc < target) check({tag, "_acc_timeout"}, 128'(n_acc), 128'(target));
  endtask

  task automatic wait_res(output int edge_no, input string tag);
    int k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) check({tag, "_res_timeout"}, 128'(res_valid), 128'd1);
    edge_no = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t, base, rbase, nacc0, nres0;
    logic ok;

    // Reset state, with a requester already pending.
    req0_valid = 1'b1; req0_data = V1; req0_key = K1;
    repeat (2) @(negedge clk);
    check("rst_ready0", 128'(req0_ready), 128'd0);
    check("rst_ready1", 128'(req1_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(res_valid), 128'd0);
    check("rst_data", aes_Data_in, 128'd0);
    check("rst_key", aes_key_in, 128'd0);
    check("rst_cipher", res_cipher, 128'd0);
    check("rst_id", 128'(res_id), 128'd0);
    check("rst_noacc", 128'(n_acc), 128'd0);

    // Single job from requester 0; data changes during RUN must not matter.
    rst = 1'b0;
    wait_acc(1, "a");
    req0_valid = 1'b0; req0_data = JUNK;
    check("a_busy", 128'(busy), 128'd1);
    check("a_hold_data", aes_Data_in, V1);
    wait_res(t, "a");
    check("a_latency", 128'(t - acc_cyc[0]), 128'd11);
    check("a_cipher", res_cipher, C1);
    check("a_id", 128'(res_id), 128'd0);
    @(negedge clk);
    check("a_idle", 128'(busy), 128'd0);
    check("a_logged", r_cip[0], C1);

    // Single job from requester 1 with its data disturbed mid-flight.
    req1_valid = 1'b1; req1_data = V2; req1_key = K2;
    wait_acc(2, "b");
    req1_valid = 1'b0; req1_data = JUNK; req1_key = JUNK;
    wait_res(t, "b");
    check("b_latency", 128'(t - acc_cyc[1]), 128'd11);
    check("b_cipher", res_cipher, C2);
    check("b_id", 128'(res_id), 128'd1);
    @(negedge clk);

    // Both requesters pending from reset: 0, 1, 0 with LATENCY+2 spacing.
    do_reset();
    base = n_acc; rbase = n_res;
    req0_valid = 1'b1; req0_data = V1; req0_key = K1;
    req1_valid = 1'b1; req1_data = V2; req1_key = K2;
    wait_acc(base + 3, "c");
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("c_first_id", 128'(acc_id[base]), 128'd0);
    check("c_second_id", 128'(acc_id[base + 1]), 128'd1);
    check("c_third_id", 128'(acc_id[base + 2]), 128'd0);
    check("c_gap1", 128'(acc_cyc[base + 1] - acc_cyc[base]), 128'(LATENCY + 2));
    check("c_gap2", 128'(acc_cyc[base + 2] - acc_cyc[base + 1]), 128'(LATENCY + 2));
    check("c_res0", r_cip[rbase], C1);
    check("c_res0_id", 128'(r_id[rbase]), 128'd0);
    check("c_res1", r_cip[rbase + 1], C2);
    check("c_res1_id", 128'(r_id[rbase + 1]), 128'd1);
    wait_res(t, "c");
    @(negedge clk);

    // Back-pressure: result held for 20 cycles with both requesters pending.
    res_ready = 1'b0;
    nacc0 = n_acc;
    req0_valid = 1'b1; req0_data = V2; req0_key = K2;
    wait_acc(nacc0 + 1, "d");
    req1_valid = 1'b1; req1_data = V1; req1_key = K1;
    wait_res(t, "d");
    nacc0 = n_acc;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(res_valid && res_cipher == C2 && res_id == 1'b0 && !req0_ready &&
            !req1_ready && busy && n_acc == nacc0)) ok = 1'b0;
    end
    check("d_hold", 128'(ok), 128'd1);
    res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("d_idle", 128'(busy), 128'd0);
    check("d_valid_low", 128'(res_valid), 128'd0);
    check("d_logged", r_cip[n_res - 1], C2);

    // Reset at counter=5 aborts the job; a fresh job then completes.
    nres0 = n_res;
    req0_valid = 1'b1; req0_data = V1; req0_key = K1;
    wait_acc(n_acc + 1, "e");
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1;
    nacc0 = n_acc;
    @(negedge clk);
    check("e_ready0", 128'(req0_ready), 128'd0);
    check("e_busy", 128'(busy), 128'd0);
    check("e_valid", 128'(res_valid), 128'd0);
    check("e_data", aes_Data_in, 128'd0);
    check("e_cipher", res_cipher, 128'd0);
    @(negedge clk);
    check("e_noacc", 128'(n_acc), 128'(nacc0));
    check("e_nores", 128'(n_res), 128'(nres0));
    rst = 1'b0;
    wait_acc(nacc0 + 1, "e2");
    req0_valid = 1'b0;
    wait_res(t, "e2");
    check("e2_latency", 128'(t - acc_cyc[n_acc - 1]), 128'd11);
    check("e2_cipher", res_cipher, C1);
    check("e2_id", 128'(res_id), 128'd0);
    @(negedge clk);
    check("e2_count", 128'(n_res), 128'(nres0 + 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001: Parameter LATENCY, default 11, is the number of clk cycles the AES_Encryption core needs from stable Data_in/key_in to valid cipher_out.
REQ-002: Parameter CNT_W, default 4, is the width of the latency down-counter; it SHALL satisfy 2^CNT_W >= LATENCY.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: req0_valid  input  1  requester 0 has a job pending.
REQ-006: req0_ready  output  1  requester 0 job accepted this cycle.
REQ-007: req0_data  input  128  requester 0 plaintext.
REQ-008: req0_key  input  128  requester 0 key.
REQ-009: req1_valid, req1_ready, req1_data, req1_key  SHALL be the same as req0_*, for requester 1.
REQ-010: aes_Data_in  output  128  plaintext driven to the core.
REQ-011: aes_key_in  output  128  key driven to the core.
REQ-012: aes_cipher_out  input  128  ciphertext returned from the core.
REQ-013: res_valid  output  1  result available.
REQ-014: res_ready  input  1  consumer accepts result.
REQ-015: res_cipher  output  128  captured ciphertext.
REQ-016: res_id  output  1  requester that owns res_cipher.
REQ-017: busy  output  1  high in RUN or DONE.

Function
REQ-018: FSM states SHALL be IDLE, RUN and DONE, with exactly one job in flight at a time.
REQ-019: In IDLE, the grant SHALL go to the single valid requester, or, if both are valid, to the requester selected by the round-robin pointer rr.
REQ-020: reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester, and at most one ready high per cycle.
REQ-021: On acceptance (reqN_valid && reqN_ready), the block SHALL register reqN_data into aes_Data_in and reqN_key into aes_key_in, record N in res_id, load the counter with LATENCY-1, and move to RUN.
REQ-022: aes_Data_in and aes_key_in SHALL stay stable from acceptance until the next acceptance.
REQ-023: In RUN, the counter SHALL decrement every cycle; at the edge where the counter is 0, aes_cipher_out SHALL be captured into res_cipher and the FSM SHALL move to DONE (capture falls on the LATENCY-th edge after the acceptance edge).
REQ-024: In DONE, res_valid SHALL be 1, with res_cipher and res_id held stable, and SHALL stay so indefinitely while res_ready is 0.
REQ-025: On res_valid && res_ready, the FSM SHALL return to IDLE, set rr to the opposite of res_id, and deassert res_valid.
REQ-026: No request SHALL be accepted in RUN or DONE; a requester may drop valid before being granted without side effects.
REQ-027: With res_ready held high and requests continuously pending, the block SHALL accept one job every LATENCY+2 cycles.
REQ-028: Requester data and key SHALL be sampled only on the acceptance edge; later changes SHALL have no effect on the in-flight job.

Reset
REQ-029: While rst is high at a clock edge, the block SHALL set state=IDLE, rr=0 (requester 0 preferred), counter=0, res_valid=0, res_cipher=0, res_id=0, aes_Data_in=0, aes_key_in=0 and busy=0.
REQ-030: req0_ready and req1_ready SHALL be 0 while rst is high.
REQ-031: A reset asserted in RUN or DONE SHALL abort the job with no result delivered; the first acceptance SHALL occur no earlier than the first edge after rst falls.

Verification
REQ-032: Stimulus: req0 data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, res_ready=1 -> response: res_valid rises after the 11th edge following acceptance, res_cipher=3925841d02dc09fbdc118597196a0b32, res_id=0.
REQ-033: Stimulus: req1 data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> response: res_cipher=69c4e0d86a7b0430d8cdb78070b4c55a, res_id=1.
REQ-034: Stimulus: both requesters valid right after reset with the two vectors above -> response: req0 served first, then req1, then req0 again if still valid; second acceptance exactly LATENCY+2 cycles after the first.
REQ-035: Stimulus: res_ready held 0 for 20 cycles in DONE -> response: res_valid, res_cipher and res_id stable, no readys asserted; one handshake cycle later the FSM is in IDLE.
REQ-036: Stimulus: rst pulsed at counter=5 in RUN -> response: no res_valid, all outputs at reset values, a new req0 job completes normally.
REQ-037: Stimulus: req0_data changed during RUN -> response: res_cipher matches the originally accepted data.
